// File: rtl/uop_split_push.sv
// Splits one vector instruction into uop_num micro-ops and pushes as many per cycle
// as the downstream uop queue can absorb, packed from push lane 0 upward.
module uop_split_push #(
  parameter type T = logic [31:0],
  parameter int unsigned M = 4,
  parameter int unsigned MAX_UOP = 8,
  localparam int unsigned UIDX_W = $clog2(MAX_UOP),
  localparam int unsigned CNT_W = $clog2(MAX_UOP) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inst_valid,
  output logic                       inst_ready,
  input  T                           inst_data,
  input  logic [CNT_W-1:0]           inst_uop_num,
  input  logic                       clear,
  input  logic [M-1:0]               almost_full,
  output logic [M-1:0]               push,
  output T     [M-1:0]               uop_data,
  output logic [M-1:0][UIDX_W-1:0]   uop_idx,
  output logic [M-1:0]               uop_last,
  output logic                       busy,
  output logic [CNT_W-1:0]           remaining
);

  localparam int unsigned SW = $clog2(M + 1);
  localparam int unsigned NW = (CNT_W > SW) ? CNT_W : SW;

  logic             busy_q;
  T                 hold_data_q;
  logic [CNT_W-1:0] hold_num_q;
  logic [CNT_W-1:0] next_idx_q;

  logic [CNT_W-1:0] rem_cnt;
  logic [NW-1:0]    rem_w;
  logic [NW-1:0]    slots;
  logic [NW-1:0]    n;
  logic             finish;
  logic             accept;

  assign rem_cnt   = hold_num_q - next_idx_q;
  assign rem_w     = NW'(rem_cnt);
  assign remaining = rem_cnt;
  assign busy      = busy_q;

  // almost_full[i] set means at most i free slots, so the lowest set bit is the free count.
  always_comb begin
    slots = NW'(M);
    for (int i = int'(M) - 1; i >= 0; i--) begin
      if (almost_full[i]) slots = NW'(i);
    end
  end

  always_comb begin
    n = '0;
    if (busy_q && !clear) n = (rem_w < slots) ? rem_w : slots;
  end

  assign finish     = busy_q && (n == rem_w) && (rem_w != '0);
  assign inst_ready = !clear && (!busy_q || finish);
  assign accept     = inst_valid && inst_ready;

  always_comb begin
    push     = '0;
    uop_idx  = '0;
    uop_last = '0;
    uop_data = '0;
    for (int j = 0; j < int'(M); j++) begin
      push[j]     = (32'(j) < 32'(n));
      uop_idx[j]  = UIDX_W'(32'(next_idx_q) + 32'(j));
      uop_last[j] = push[j] && ((32'(next_idx_q) + 32'(j)) == (32'(hold_num_q) - 32'd1));
      uop_data[j] = hold_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      hold_data_q <= '0;
      hold_num_q  <= '0;
      next_idx_q  <= '0;
    end else if (clear) begin
      busy_q      <= 1'b0;
      hold_data_q <= '0;
      hold_num_q  <= '0;
      next_idx_q  <= '0;
    end else if (accept) begin
      busy_q      <= 1'b1;
      hold_data_q <= inst_data;
      hold_num_q  <= (inst_uop_num == '0) ? CNT_W'(1) : inst_uop_num;
      next_idx_q  <= '0;
    end else if (busy_q) begin
      next_idx_q <= next_idx_q + CNT_W'(n);
      if (finish) busy_q <= 1'b0;
    end
  end

`ifdef ASSERT_ON
  logic [M-1:0] top_bit;
  assign top_bit = {1'b1, {(M-1){1'b0}}};

  a_uop_num_range: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> (inst_uop_num >= CNT_W'(1) && 32'(inst_uop_num) <= MAX_UOP));
  a_af_monotonic: assert property (@(posedge clk) disable iff (!rst_n)
    ((almost_full & ~(almost_full >> 1)) & ~top_bit) == '0);
  a_push_le_slots: assert property (@(posedge clk) disable iff (!rst_n)
    32'($countones(push)) <= 32'(slots));
  a_last_has_push: assert property (@(posedge clk) disable iff (!rst_n)
    (uop_last & ~push) == '0);
`endif

endmodule

// File: doc/uop_split_push.md
Name: uop_split_push

Overview:
- Upstream feeder of the vector uop queue (multi-push/multi-pop FIFO, M push lanes).
- Accepts one vector instruction per handshake and splits it into uop_num micro-ops; uop count depends on LMUL/EMUL and is resolved by decode.
- Each cycle, pushes as many uops as the queue can absorb (up to M), packed from push lane 0 upward.
- Free space comes from the queue's almost_full vector; the block holds the instruction until its last uop is pushed.

Parameters:
- T: default logic [31:0]. Instruction payload type.
- M: default 4. Push lanes; must equal the queue's push width.
- MAX_UOP: default 8. Maximum uops per instruction.
- UIDX_W: default $clog2(MAX_UOP). Uop index width (localparam).
- CNT_W: default $clog2(MAX_UOP)+1. uop_num / remaining width (localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- inst_valid  in  1  instruction offered.
- inst_ready  out  1  instruction accepted when inst_valid & inst_ready.
- inst_data  in  T  instruction payload.
- inst_uop_num  in  CNT_W  uop count, legal range 1..MAX_UOP.
- clear  in  1  synchronous flush; drops any held instruction.
- almost_full  in  M  from the queue; bit i=1 means free slots <= i.
- push  out  M  to the queue; contiguous ones from lane 0.
- uop_data  out  M x T  per-lane payload (copy of the held inst_data).
- uop_idx  out  M x UIDX_W  per-lane uop index.
- uop_last  out  M  per-lane flag: lane carries index uop_num-1.
- busy  out  1  an instruction is held.
- remaining  out  CNT_W  uops not yet pushed for the held instruction.

Behaviour:
- State registers:
  - busy.
  - hold_data (T).
  - hold_num (CNT_W).
  - next_idx (CNT_W).
  - remaining = hold_num - next_idx (combinational from registers).
- Reset (async) and clear (sync, highest priority after reset):
  - busy=0, next_idx=0, hold_num=0, hold_data='0.
  - Resulting outputs: push=0, remaining=0, inst_ready=1.
  - clear also blocks acceptance in its own cycle: inst_ready=0 while clear=1.
- Slot count:
  - slots = M if almost_full[M-1]==0.
  - Otherwise slots = smallest i with almost_full[i]==1 (so almost_full[0]=1 gives 0).
  - Assumes the almost_full bits are monotonic; non-monotonic input is flagged by an assertion.
- Issue per cycle (only when busy & !clear):
  - n = min(remaining, slots).
  - push[j] = (j < n).
  - uop_idx[j] = next_idx + j, truncated to UIDX_W.
  - uop_last[j] = push[j] & (next_idx + j == hold_num - 1).
  - uop_data[j] = hold_data for all lanes.
  - push, uop_idx and uop_last are combinational from registers plus almost_full; no latency beyond the holding register.
  - next_idx <= next_idx + n.
- Completion:
  - finish = busy & (n == remaining) & (remaining != 0).
  - On finish, busy clears unless a new instruction is accepted in the same cycle.
- Accept:
  - inst_ready = !clear & (!busy | finish).
  - On accept: hold_data <= inst_data, hold_num <= inst_uop_num (0 coerced to 1), next_idx <= 0, busy <= 1.
  - First pushes of the new instruction occur the cycle after accept.
  - Back-to-back accept in the finish cycle gives zero bubble between instructions.
- Stall:
  - slots==0: push=0, all state holds, inst_ready=0 while busy.
- Invariants:
  - Uops are pushed in strictly increasing index order, never duplicated or skipped.
  - Exactly one lane has uop_last=1 per instruction, in the finish cycle.
- Assertions (ASSERT_ON):
  - inst_uop_num in 1..MAX_UOP on accept.
  - almost_full monotonic.
  - push never exceeds slots.
  - uop_last implies push.

Test Plan (M=4, MAX_UOP=8):
1. Reset, then accept an instruction with uop_num=8, almost_full=0000.
   - Cycle 1: push=1111, idx 0..3, uop_last=0000.
   - Cycle 2: push=1111, idx 4..7, uop_last=1000, inst_ready=1.
   - A second instruction offered in cycle 2 is accepted, and its idx 0 appears in cycle 3.
2. uop_num=3 with almost_full=1100 (2 free).
   - push=0011, idx 0,1, remaining 3->1.
   - Next cycle, almost_full=0000: push=0001, idx 2, uop_last=0001, busy drops.
3. Held instruction with almost_full=1111.
   - push=0000 and remaining/next_idx stay constant for 5 cycles, inst_ready=0.
   - Release to 0000: push resumes at the stalled index.
4. uop_num=1 instructions offered every cycle, queue never full.
   - One push per cycle on lane 0 with uop_last=0001.
   - inst_ready stays 1 throughout.
5. clear asserted after 4 of 8 uops are pushed.
   - Next cycle: push=0, busy=0, remaining=0.
   - inst_ready=0 during clear, 1 afterwards; a new instruction restarts at idx 0.
6. rst_n pulsed low asynchronously mid-split.
   - push=0, busy=0 and inst_ready=1 immediately, without waiting for a clock edge.
   - After release, no stale uops are pushed.
